// File: rtl/fact_pkg.sv
// fact_pkg: shared types and defaults for the factorial arbiter slice.
//   state_t      - 2-bit FSM encoding (IDLE/LOAD/CALC/DONE)
//   FACT_W       - default operand/result width
//   FACT_NUM_REQ - default requester count
package fact_pkg;

    localparam int FACT_W       = 32;
    localparam int FACT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CALC = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/fact_rr_pick.sv
// fact_rr_pick: combinational round-robin picker.
// Scans req starting at rr_ptr, wrapping upward, and returns the first set bit.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  IW       highest-priority index this round
//   pick   out NUM_REQ  one-hot of the chosen requester (0 when none)
//   idx    out IW       index of the chosen requester
//   any    out 1        at least one request present
module fact_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IW-1:0]      idx,
    output logic               any
);

    always_comb begin
        int          j;
        logic [IW-1:0] jj;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        jj   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rotate the scan origin; NUM_REQ need not be a power of two
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = j[IW-1:0];
            if (!any && req[jj]) begin
                any      = 1'b1;
                pick[jj] = 1'b1;
                idx      = jj;
            end
        end
    end

endmodule

// File: rtl/fact_arbiter.sv
// fact_arbiter: round-robin arbiter in front of one shared iterative factorial
// datapath (acc *= cnt, cnt -= 1, one multiply per cycle). One job in flight.
// Optional feature macro: FACT_OVF_DETECT_EN (full 2W-bit product, sticky
// overflow flag reported on ovf with done). Undefined: ovf tied to 0.
// Ports:
//   clk   in  1           rising-edge clock
//   rst_n in  1           async active-low reset
//   req   in  NUM_REQ     level requests, held until done
//   n_in  in  NUM_REQ*W   operands, requester i at [i*W +: W]
//   gnt   out NUM_REQ     one-hot grant, LOAD through DONE
//   busy  out 1           high outside IDLE
//   done  out NUM_REQ     one-cycle one-hot completion pulse
//   f     out W           result, valid with done, held otherwise
//   ovf   out 1           overflow flag, valid with done
module fact_arbiter
    import fact_pkg::*;
#(
    parameter int NUM_REQ = FACT_NUM_REQ,
    parameter int W       = FACT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] n_in,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 busy,
    output logic [NUM_REQ-1:0]   done,
    output logic [W-1:0]         f,
    output logic                 ovf
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t               state;
    logic [IW-1:0]        rr_ptr;
    logic [IW-1:0]        sel;
    logic [W-1:0]         acc;
    logic [W-1:0]         cnt;

    logic [NUM_REQ-1:0][W-1:0] n_arr;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IW-1:0]        pick_idx;
    logic                 pick_any;
    logic [IW-1:0]        sel_next;
    logic [W-1:0]         prod_lo;

    assign n_arr    = n_in;
    assign sel_next = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

    fact_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef FACT_OVF_DETECT_EN
    logic [2*W-1:0] prod;
    logic           prod_hi_nz;
    logic           ovf_flag;
    assign prod       = {{W{1'b0}}, acc} * {{W{1'b0}}, cnt};
    assign prod_lo    = prod[W-1:0];
    assign prod_hi_nz = |prod[2*W-1:W];
`else
    assign prod_lo = acc * cnt;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= '0;
            sel    <= '0;
            acc    <= '0;
            cnt    <= '0;
            gnt    <= '0;
            busy   <= 1'b0;
            done   <= '0;
            f      <= '0;
`ifdef FACT_OVF_DETECT_EN
            ovf      <= 1'b0;
            ovf_flag <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        sel   <= pick_idx;
                        gnt   <= pick_oh;
                        busy  <= 1'b1;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    acc   <= W'(1);
                    cnt   <= n_arr[sel];
`ifdef FACT_OVF_DETECT_EN
                    ovf_flag <= 1'b0;
`endif
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    // n=0 and n=1 both leave acc=1
                    if (cnt < W'(2)) begin
                        done   <= gnt;
                        f      <= acc;
                        rr_ptr <= sel_next;
`ifdef FACT_OVF_DETECT_EN
                        ovf    <= ovf_flag;
`endif
                        state  <= ST_DONE;
                    end else begin
                        acc <= prod_lo;
                        cnt <= cnt - W'(1);
`ifdef FACT_OVF_DETECT_EN
                        ovf_flag <= ovf_flag | prod_hi_nz;
`endif
                    end
                end
                ST_DONE: begin
                    done  <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
`ifdef FACT_OVF_DETECT_EN
                    ovf   <= 1'b0;
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fact_arbiter.md
Name: fact_arbiter

Overview:
Round-robin arbiter and sequencer sharing one iterative factorial datapath (accumulator × down-counter, one multiply per cycle) among NUM_REQ requesters. It captures the granted requester's operand, runs the multiply loop to completion and returns the result with a one-cycle done pulse. It sits between the client blocks and the single shared multiplier, so only one factorial is in flight at a time.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 32, operand/result width; arithmetic is modulo 2^W

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester; held until its done pulse
n_in  in  NUM_REQ*W  operands, requester i at bits [i*W +: W]; stable while req[i] is high
gnt  out  NUM_REQ  one-hot; high from LOAD through DONE for the served requester
busy  out  1  high in every state except IDLE
done  out  NUM_REQ  one-hot, one-cycle pulse in DONE
f  out  W  result; valid while done is nonzero, holds last result otherwise
ovf  out  1  overflow flag, valid with done (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, gnt=0, done=0, busy=0, f=0, ovf=0, rr_ptr=0, acc=0, cnt=0. Reset mid-computation aborts it; no done pulse is issued.
- States: IDLE, LOAD, CALC, DONE (2-bit encoding).
- IDLE: if any req is set, select the first set bit starting at rr_ptr, wrapping upward (rr_ptr, rr_ptr+1, … mod NUM_REQ). Register sel, go to LOAD. If req=0, stay in IDLE.
- LOAD: gnt[sel]=1, acc=1, cnt=n_in[sel], go to CALC.
- CALC: if cnt<=1, go to DONE. Otherwise acc=acc*cnt (low W bits kept), cnt=cnt-1, stay in CALC.
- DONE: done[sel]=1 for exactly one cycle, f=acc, rr_ptr=(sel+1) mod NUM_REQ, gnt=0 on exit, go to IDLE.
- Latency: req seen in IDLE at cycle 0 gives done at cycle max(n,1)+2. n=0 and n=1 both give f=1 at cycle 3.
- Back-to-back: the earliest next grant decision is the IDLE cycle after DONE. Idle gap between jobs is 1 cycle.
- Simultaneous requests: exactly one is granted. Fairness: a continuously asserted req is served within NUM_REQ jobs.
- req[sel] dropped while in service: the job still completes and done[sel] still pulses. Requests that change or drop while not selected have no effect.
- n_in is sampled only in LOAD; later changes are ignored.
- Overflow wraps silently modulo 2^W (e.g. W=32, n=13 gives 0x17328CC00 truncated to 0x7328CC00).

Optional Feature:
FACT_OVF_DETECT_EN
- Defined: CALC computes the full 2W-bit product; a sticky flag is set if any upper W bits are nonzero during the job. ovf = flag in DONE. The flag clears in LOAD.
- Undefined: ovf is tied to 0, and only a W-bit product is built.

Decomposition:
- Package fact_pkg: state encodings (ST_IDLE=2'b00, ST_LOAD=2'b01, ST_CALC=2'b10, ST_DONE=2'b11) and the default W.
- Sub-module fact_rr_pick: combinational round-robin picker (req, rr_ptr in; one-hot pick and index out), reused by later arbiters.
- The multiply/counter datapath stays inline in fact_arbiter.

Test Plan:
- Reset then single req[0], n=5: done[0] at cycle 7, f=120, gnt[0] high cycles 1..7, ovf=0.
- req[2] with n=0, then separately n=1: each gives done[2] at cycle 3, f=1.
- req=4'b1111, n={3,4,5,6} for requesters 0..3, held: service order 0,1,2,3,0. Results 6,24,120,720; one done pulse each; never two gnt bits set.
- After serving requester 1 (rr_ptr=2), req=4'b0011: requester 0 is served before requester 1.
- n=13, W=32: f=0x7328CC00. ovf=1 with FACT_OVF_DETECT_EN defined, 0 without. n=12 gives f=479001600, ovf=0.
- rst_n pulsed low during CALC of n=10: outputs return to reset values immediately, no done pulse. A fresh req afterwards completes normally with f=3628800.
